chacha_qr_seq: RTL
==================

Name: chacha_qr_seq

Overview:
- Sequencer that runs a full ChaCha quarter round on two independent 32-bit lanes packed into 64-bit registers a, b, c, d (lane 0 = bits 31:0, lane 1 = bits 63:32).
- Performs the packed adds internally.
- Delegates every xor-rotate step to the existing combinational packed xor-rotate unit through the xr_* port group, in the same cycle.
- Sits directly upstream of that unit; the core feeds it state via a valid/ready handshake.

Parameters:
- ITER, 1, number of back-to-back quarter-round passes applied to the latched state before output (1..15).

Ports:
- g_clk  input  1  clock; all state updates on rising edge
- g_reset  input  1  synchronous, active-high reset
- in_valid  input  1  input words valid
- in_ready  output  1  block can accept input
- in_a, in_b, in_c, in_d  input  64 each  packed state words
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_a, out_b, out_c, out_d  output  64 each  packed result words
- xr_rs1  output  64  xor-rotate operand 1
- xr_rs2  output  64  xor-rotate operand 2
- xr_op_16, xr_op_12, xr_op_8, xr_op_7  output  1 each  one-hot rotate select
- xr_rd  input  64  xor-rotate result, combinational from xr_* outputs

Behaviour:
- States: IDLE, RUN, DONE.
  - Step counter: 3 bits, 0..7.
  - Iteration counter: 4 bits.
- Reset (g_reset=1 at an edge, any state, including mid-RUN):
  - state=IDLE; counters=0.
  - a, b, c, d registers=0; out_valid=0.
  - Any in-flight operation is discarded.
- in_ready = (state==IDLE). Combinational from state only.
- IDLE:
  - On in_valid & in_ready: latch in_a..in_d, clear both counters, go to RUN.
- RUN: one step commits per cycle, in this order:
  - step0: a=a+b
  - step1: d=rol16(d^a)
  - step2: c=c+d
  - step3: b=rol12(b^c)
  - step4: a=a+b
  - step5: d=rol8(d^a)
  - step6: c=c+d
  - step7: b=rol7(b^c)
- Adds: per-lane modulo 2^32. No carry from bit 31 into bit 32.
- Xor-rotate steps:
  - xr_rs1 = destination register (d or b).
  - xr_rs2 = source (a or c).
  - Exactly one xr_op asserted; the result register takes xr_rd.
- Non-xor-rotate cycles (all states, and add steps): xr_rs1=0, xr_rs2=0, all xr_op=0.
- Step 7 behaviour:
  - If iteration==ITER-1, go to DONE.
  - Otherwise increment iteration and restart at step0 on the updated state.
- DONE:
  - out_valid=1; out_a..out_d = a..d registers.
  - Held stable until out_valid & out_ready, then go to IDLE.
- Latency: out_valid rises exactly 8*ITER cycles after the accepting edge.
  - No input accepted in RUN or DONE, so there is no same-cycle output/input overlap.
  - A new input is accepted one cycle after the handshake, at the earliest.
- out_a..out_d reset to 0. They read registered state at all times; only DONE makes them valid.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Decomposition:
- Shared package chacha_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - step index constants
  - rotate-amount constants 16/12/8/7
  - one-hot xor-rotate select typedef
- Sub-module chacha_add2x32: combinational packed 2x32 lane adder. Used for the add steps.
- The xor-rotate unit stays external and is connected by the parent.

Test Plan:
- RFC 7539 2.1.1 vector: lane0 a=0x11111111, b=0x01020304, c=0x9b8d6f43, d=0x01234567; lane1 all 0; ITER=1.
  - Required: lane0 a=0xea2a92f4, b=0xcb1cf8ce, c=0x4581472e, d=0x5881c4bb; lane1 stays 0.
  - out_valid exactly 8 cycles after accept.
- Same vector placed in lane1, lane0=0.
  - Required: identical results in bits 63:32, zeros in 31:0. Proves no cross-lane carry.
- Carry boundary: a=b=0xffffffff in both lanes, c=d=0.
  - Check step0 commits a=0xfffffffe in each lane.
  - Check xr_rs1/xr_rs2/xr_op_16 at step1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Required: outputs stable, in_ready=0, in_valid ignored.
  - On release: IDLE next cycle, then the next input accepted.
- Reset mid-operation: assert g_reset at step 4.
  - Required next cycle: IDLE, out_valid=0, all outputs 0, in_ready=1.
  - A fresh vector then completes correctly.
- ITER=2 build:
  - Required: result equals two sequential quarter rounds computed by the reference model; out_valid after 16 cycles.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared types and constants for the packed two-lane ChaCha quarter-round sequencer.
package chacha_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step index within one quarter round; one step commits per RUN cycle.
  typedef logic [2:0] step_t;

  localparam step_t STEP_ADD_AB_0 = 3'd0;  // a = a + b
  localparam step_t STEP_XR_D_16  = 3'd1;  // d = rol16(d ^ a)
  localparam step_t STEP_ADD_CD_0 = 3'd2;  // c = c + d
  localparam step_t STEP_XR_B_12  = 3'd3;  // b = rol12(b ^ c)
  localparam step_t STEP_ADD_AB_1 = 3'd4;  // a = a + b
  localparam step_t STEP_XR_D_8   = 3'd5;  // d = rol8(d ^ a)
  localparam step_t STEP_ADD_CD_1 = 3'd6;  // c = c + d
  localparam step_t STEP_XR_B_7   = 3'd7;  // b = rol7(b ^ c)

  // Rotate amounts used by the quarter round.
  typedef logic [4:0] rot_t;

  localparam rot_t ROT_16 = 5'd16;
  localparam rot_t ROT_12 = 5'd12;
  localparam rot_t ROT_8  = 5'd8;
  localparam rot_t ROT_7  = 5'd7;

  // One-hot rotate select presented to the external xor-rotate unit.
  typedef struct packed {
    logic op_16;
    logic op_12;
    logic op_8;
    logic op_7;
  } xr_sel_t;

  localparam xr_sel_t XR_SEL_NONE = '0;

  // Map a rotate amount onto the one-hot select lines.
  function automatic xr_sel_t rot_sel(input rot_t amt);
    xr_sel_t sel;
    sel.op_16 = (amt == ROT_16);
    sel.op_12 = (amt == ROT_12);
    sel.op_8  = (amt == ROT_8);
    sel.op_7  = (amt == ROT_7);
    return sel;
  endfunction

endpackage

// File: rtl/chacha_add2x32.sv
// Combinational packed adder: two independent 32-bit lanes, each modulo 2^32.
module chacha_add2x32 (
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic [63:0] sum
);

  // Lanes are added separately so no carry crosses from bit 31 into bit 32.
  always_comb begin
    sum[31:0]  = x[31:0]  + y[31:0];
    sum[63:32] = x[63:32] + y[63:32];
  end

endmodule

// File: rtl/chacha_qr_seq.sv
// Two-lane ChaCha quarter-round sequencer. Adds are done locally; each
// xor-rotate step is handed to an external combinational unit via xr_*.
module chacha_qr_seq
  import chacha_pkg::*;
#(
  parameter int unsigned ITER = 1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic [63:0] in_c,
  input  logic [63:0] in_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_a,
  output logic [63:0] out_b,
  output logic [63:0] out_c,
  output logic [63:0] out_d,
  output logic [63:0] xr_rs1,
  output logic [63:0] xr_rs2,
  output logic        xr_op_16,
  output logic        xr_op_12,
  output logic        xr_op_8,
  output logic        xr_op_7,
  input  logic [63:0] xr_rd
);

  localparam logic [3:0] ITER_LAST = 4'(ITER - 1);

  state_t      state;
  state_t      state_next;
  step_t       step;
  logic [3:0]  iter;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] c;
  logic [63:0] d;
  logic [63:0] add_x;
  logic [63:0] add_y;
  logic [63:0] add_sum;
  xr_sel_t     xr_sel;
  logic        last_step;
  logic        last_pass;

  assign last_step = (step == STEP_XR_B_7);
  assign last_pass = (iter == ITER_LAST);

  // State register.
  always_ff @(posedge g_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (g_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      IDLE: if (in_valid && in_ready)        state_next = RUN;
      RUN:  if (last_step && last_pass)      state_next = DONE;
      DONE: if (out_ready)                   state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  // Handshake and xor-rotate port drive; xr_* are idle except on rotate steps.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    xr_rs1    = '0;
    xr_rs2    = '0;
    xr_sel    = XR_SEL_NONE;
    if (state == RUN) begin
      case (step)
        STEP_XR_D_16: begin xr_rs1 = d; xr_rs2 = a; xr_sel = rot_sel(ROT_16); end
        STEP_XR_B_12: begin xr_rs1 = b; xr_rs2 = c; xr_sel = rot_sel(ROT_12); end
        STEP_XR_D_8:  begin xr_rs1 = d; xr_rs2 = a; xr_sel = rot_sel(ROT_8);  end
        STEP_XR_B_7:  begin xr_rs1 = b; xr_rs2 = c; xr_sel = rot_sel(ROT_7);  end
        default:      ;
      endcase
    end
  end

  assign xr_op_16 = xr_sel.op_16;
  assign xr_op_12 = xr_sel.op_12;
  assign xr_op_8  = xr_sel.op_8;
  assign xr_op_7  = xr_sel.op_7;

  // Adder operand select: a+b on the a-steps, c+d otherwise.
  always_comb begin
    add_x = c;
    add_y = d;
    if (step == STEP_ADD_AB_0 || step == STEP_ADD_AB_1) begin
      add_x = a;
      add_y = b;
    end
  end

  chacha_add2x32 u_add (
    .x   (add_x),
    .y   (add_y),
    .sum (add_sum)
  );

  // Working state and counters: latch on accept, commit one step per RUN cycle.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      step <= '0;
      iter <= '0;
      a    <= '0;
      b    <= '0;
      c    <= '0;
      d    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a    <= in_a;
            b    <= in_b;
            c    <= in_c;
            d    <= in_d;
            step <= '0;
            iter <= '0;
          end
        end
        RUN: begin
          case (step)
            STEP_ADD_AB_0, STEP_ADD_AB_1: a <= add_sum;
            STEP_XR_D_16,  STEP_XR_D_8:   d <= xr_rd;
            STEP_ADD_CD_0, STEP_ADD_CD_1: c <= add_sum;
            STEP_XR_B_12,  STEP_XR_B_7:   b <= xr_rd;
            default:                      ;
          endcase
          // Step wraps 7 -> 0 so the next pass starts on the updated state.
          step <= step + 3'd1;
          if (last_step && !last_pass) begin
            iter <= iter + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_a = a;
  assign out_b = b;
  assign out_c = c;
  assign out_d = d;

endmodule
